// File: rtl/usb_speed_autodetect_if.sv
// Register-block / PHY-side signal bundle for the USB speed autodetect sequencer.
// slave = sequencer side, master = register block / linestate driver side.
interface usb_speed_autodetect_if #(
    parameter int CW = 24
);
    logic          restart_i;
    logic [CW-1:0] wait1_i;
    logic [CW-1:0] wait2_i;
    logic [1:0]    xcvrsel_dflt_i;
    logic          termsel_dflt_i;
    logic [1:0]    linestate_i;
    logic [1:0]    speed_o;
    logic [1:0]    xcvrsel_o;
    logic          termsel_o;
    logic          busy_o;
    logic          done_o;

    modport slave (
        input  restart_i, wait1_i, wait2_i, xcvrsel_dflt_i, termsel_dflt_i, linestate_i,
        output speed_o, xcvrsel_o, termsel_o, busy_o, done_o
    );

    modport master (
        output restart_i, wait1_i, wait2_i, xcvrsel_dflt_i, termsel_dflt_i, linestate_i,
        input  speed_o, xcvrsel_o, termsel_o, busy_o, done_o
    );
endinterface

// File: rtl/usb_speed_autodetect.sv
// Sniffer-side USB speed autodetection sequencer (bus reset, device chirp, host K-J chirps).
// Optional macro USB_AUTO_LS_DETECT_EN: a debounced K in WAIT_IDLE reports low speed.
//
//  state        | meaning
//  -------------+---------------------------------------------------------------
//  S_IDLE       | after reset, waiting for the first restart pulse
//  S_WAIT_IDLE  | debouncing a stable J (or K) idle level
//  S_WAIT_RESET | counting SE0 cycles until a bus reset qualifies
//  S_WAIT_CHIRP | chirp window open, looking for the device K chirp
//  S_HOST_KJ    | counting qualified host K<->J chirp edges
//  S_DONE       | result valid, holding until the next restart
module usb_speed_autodetect #(
    parameter int pUSB_AUTO_COUNTER_WIDTH = 24,
    parameter int pDEBOUNCE               = 16,
    parameter int pCHIRP_K_MIN            = 60,
    parameter int pCHIRP_KJ_MIN           = 30,
    parameter int pKJ_COUNT               = 6
) (
    input  logic                  fe_clk,
    input  logic                  reset_n,
    usb_speed_autodetect_if.slave bus
);
    localparam int CW = pUSB_AUTO_COUNTER_WIDTH;

    localparam logic [CW-1:0] DEB_MAX   = CW'(pDEBOUNCE);
    localparam logic [CW-1:0] K_MIN     = CW'(pCHIRP_K_MIN);
    localparam logic [CW-1:0] KJ_MIN    = CW'(pCHIRP_KJ_MIN);
    localparam logic [CW-1:0] KJ_EDGES  = CW'(pKJ_COUNT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam logic [1:0] SPD_HS = 2'b00;
    localparam logic [1:0] SPD_FS = 2'b01;
    localparam logic [1:0] SPD_LS = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_RESET,
        S_WAIT_CHIRP,
        S_HOST_KJ,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic [CW-1:0] se0_cnt_q, se0_cnt_d;
    logic [CW-1:0] win_cnt_q, win_cnt_d;
    logic [CW-1:0] k_cnt_q, k_cnt_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic [1:0]    ls_prev_q, ls_prev_d;
    logic [1:0]    level_q, level_d;
    logic [1:0]    speed_q, speed_d;
    logic [1:0]    xcvrsel_q, xcvrsel_d;
    logic          termsel_q, termsel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          go_done;
    logic [1:0]    done_spd;
    logic [CW-1:0] wait1_eff;
    logic [1:0]    ls;

    assign ls        = bus.linestate_i;
    assign wait1_eff = (bus.wait1_i == '0) ? CNT_ONE : bus.wait1_i;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // {xcvrsel, termsel} the PHY is left in once a speed is known
    function automatic logic [2:0] phy_cfg(input logic [1:0] spd);
        case (spd)
            SPD_HS:  phy_cfg = 3'b000;
            SPD_LS:  phy_cfg = 3'b101;
            default: phy_cfg = 3'b011;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        se0_cnt_d  = se0_cnt_q;
        win_cnt_d  = win_cnt_q;
        k_cnt_d    = k_cnt_q;
        hold_cnt_d = hold_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ls_prev_d  = ls;
        level_d    = level_q;
        speed_d    = speed_q;
        xcvrsel_d  = xcvrsel_q;
        termsel_d  = termsel_q;
        busy_d     = busy_q;
        done_d     = done_q;
        go_done    = 1'b0;
        done_spd   = SPD_FS;

        case (state_q)
            S_IDLE: begin
            end

            S_WAIT_IDLE: begin
                if (ls == LS_SE0 || ls == LS_SE1) begin
                    deb_cnt_d = '0;
                end else begin
                    if (ls != ls_prev_q || deb_cnt_q == '0) begin
                        deb_cnt_d = CNT_ONE;
                    end else begin
                        deb_cnt_d = sat_inc(deb_cnt_q);
                    end
                    if (deb_cnt_d >= DEB_MAX) begin
                        deb_cnt_d = '0;
                        if (ls == LS_J) begin
                            state_d = S_WAIT_RESET;
                        end else begin
`ifdef USB_AUTO_LS_DETECT_EN
                            go_done  = 1'b1;
                            done_spd = SPD_LS;
`endif
                        end
                    end
                end
            end

            S_WAIT_RESET: begin
                se0_cnt_d = (ls == LS_SE0) ? sat_inc(se0_cnt_q) : '0;
                if (se0_cnt_d >= wait1_eff) begin
                    state_d    = S_WAIT_CHIRP;
                    se0_cnt_d  = '0;
                    win_cnt_d  = '0;
                    k_cnt_d    = '0;
                    hold_cnt_d = '0;
                    edge_cnt_d = '0;
                end
            end

            S_WAIT_CHIRP: begin
                win_cnt_d = sat_inc(win_cnt_q);
                k_cnt_d   = (ls == LS_K) ? sat_inc(k_cnt_q) : '0;
                if (k_cnt_d >= K_MIN) begin
                    state_d    = S_HOST_KJ;
                    level_d    = LS_K;
                    hold_cnt_d = '0;
                    edge_cnt_d = '0;
                end else if (win_cnt_q >= bus.wait2_i || ls == LS_J) begin
                    go_done  = 1'b1;
                    done_spd = SPD_FS;
                end
            end

            S_HOST_KJ: begin
                win_cnt_d = sat_inc(win_cnt_q);
                // SE0/SE1 cycles neither extend nor break the current level
                if (ls == LS_J || ls == LS_K) begin
                    if (ls != level_q) begin
                        level_d    = ls;
                        hold_cnt_d = CNT_ONE;
                        edge_cnt_d = (hold_cnt_q >= KJ_MIN) ? sat_inc(edge_cnt_q) : '0;
                    end else begin
                        hold_cnt_d = sat_inc(hold_cnt_q);
                    end
                end
                // a qualifying last edge wins over a window expiry in the same cycle
                if (edge_cnt_d >= KJ_EDGES) begin
                    go_done  = 1'b1;
                    done_spd = SPD_HS;
                end else if (win_cnt_q >= bus.wait2_i) begin
                    go_done  = 1'b1;
                    done_spd = SPD_FS;
                end
            end

            S_DONE: begin
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_done) begin
            state_d                  = S_DONE;
            speed_d                  = done_spd;
            {xcvrsel_d, termsel_d}   = phy_cfg(done_spd);
            busy_d                   = 1'b0;
            done_d                   = 1'b1;
        end

        if (bus.restart_i) begin
            state_d    = S_WAIT_IDLE;
            deb_cnt_d  = '0;
            se0_cnt_d  = '0;
            win_cnt_d  = '0;
            k_cnt_d    = '0;
            hold_cnt_d = '0;
            edge_cnt_d = '0;
            level_d    = LS_J;
            xcvrsel_d  = bus.xcvrsel_dflt_i;
            termsel_d  = bus.termsel_dflt_i;
            busy_d     = 1'b1;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            deb_cnt_q  <= '0;
            se0_cnt_q  <= '0;
            win_cnt_q  <= '0;
            k_cnt_q    <= '0;
            hold_cnt_q <= '0;
            edge_cnt_q <= '0;
            ls_prev_q  <= LS_SE0;
            level_q    <= LS_J;
            speed_q    <= SPD_FS;
            xcvrsel_q  <= 2'b01;
            termsel_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            se0_cnt_q  <= se0_cnt_d;
            win_cnt_q  <= win_cnt_d;
            k_cnt_q    <= k_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ls_prev_q  <= ls_prev_d;
            level_q    <= level_d;
            speed_q    <= speed_d;
            xcvrsel_q  <= xcvrsel_d;
            termsel_q  <= termsel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.speed_o   = speed_q;
    assign bus.xcvrsel_o = xcvrsel_q;
    assign bus.termsel_o = termsel_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
endmodule
